filter_sel_encoder: RTL and testbench



---
 rtl/filter_enc_pkg.sv | 16 +
 rtl/filter_sel_encoder_find_first_n.sv | 36 +++
 rtl/filter_sel_encoder.sv | 107 ++++++++++
 tb/tb_filter_sel_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_enc_pkg.sv
// Shared types and helpers for the filter-select encoder/decoder pair.
package filter_enc_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  // Width of a channel index field; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Flat slot number of slot s in macro m.
  function automatic int slot_index(input int m, input int s, input int max_num_filter);
    return m * max_num_filter + s;
  endfunction

endpackage

// File: rtl/filter_sel_encoder_find_first_n.sv
// Picks the MAX_NUM_FILTER lowest set bits of one macro's mask and
// returns their indices, valid flags and the mask with those bits cleared.
module find_first_n #(
  parameter int OUT_CH         = 64,
  parameter int MAX_NUM_FILTER = 1,
  parameter int BIT_OUT_CH     = 6
) (
  input  logic [OUT_CH-1:0]                    mask,
  output logic [MAX_NUM_FILTER*BIT_OUT_CH-1:0] idx,
  output logic [MAX_NUM_FILTER-1:0]            vld,
  output logic [OUT_CH-1:0]                    rest
);

  logic [OUT_CH-1:0] work;
  logic              found;

  always_comb begin
    work  = mask;
    idx   = '0;
    vld   = '0;
    found = 1'b0;
    for (int unsigned s = 0; s < MAX_NUM_FILTER; s++) begin
      found = 1'b0;
      for (int unsigned c = 0; c < OUT_CH; c++) begin
        if (!found && work[c]) begin
          found                          = 1'b1;
          idx[s*BIT_OUT_CH +: BIT_OUT_CH] = BIT_OUT_CH'(c);
          work[c]                        = 1'b0;
        end
      end
      vld[s] = found;
    end
    rest = work;
  end

endmodule

// File: rtl/filter_sel_encoder.sv
// Serialises a multi-hot per-macro select bitmap into packed WHICH_FILTER
// index beats with ready/valid handshakes on both sides.
module filter_sel_encoder
  import filter_enc_pkg::*;
#(
  parameter  int NUM_MACRO      = 1,
  parameter  int OUT_CH         = 64,
  parameter  int MAX_NUM_FILTER = 1,
  localparam int BIT_OUT_CH     = idx_width(OUT_CH)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_MACRO*OUT_CH-1:0]                   SEL_MASK,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_MACRO*MAX_NUM_FILTER*BIT_OUT_CH-1:0] WHICH_FILTER,
  output logic [NUM_MACRO*MAX_NUM_FILTER-1:0]           FILTER_VLD,
  output logic                                          out_last
);

  localparam int SLOTS = NUM_MACRO * MAX_NUM_FILTER;

  state_t state_q, state_d;

  logic [NUM_MACRO*OUT_CH-1:0]          src_mask;
  logic [NUM_MACRO*OUT_CH-1:0]          rem_q;
  logic [NUM_MACRO*OUT_CH-1:0]          rem_d;
  logic [MAX_NUM_FILTER*BIT_OUT_CH-1:0] macro_idx [NUM_MACRO];
  logic [MAX_NUM_FILTER-1:0]            macro_vld [NUM_MACRO];
  logic [SLOTS*BIT_OUT_CH-1:0]          wf_d;
  logic [SLOTS-1:0]                     fv_d;

  logic accept, advance, finish;

  // In IDLE the finder looks at the incoming mask so beat 0 lands one cycle after accept.
  assign src_mask = (state_q == IDLE) ? SEL_MASK : rem_q;

  for (genvar m = 0; m < NUM_MACRO; m++) begin : g_macro
    find_first_n #(
      .OUT_CH         (OUT_CH),
      .MAX_NUM_FILTER (MAX_NUM_FILTER),
      .BIT_OUT_CH     (BIT_OUT_CH)
    ) u_find (
      .mask (src_mask[m*OUT_CH +: OUT_CH]),
      .idx  (macro_idx[m]),
      .vld  (macro_vld[m]),
      .rest (rem_d[m*OUT_CH +: OUT_CH])
    );
  end

  always_comb begin
    wf_d = '0;
    fv_d = '0;
    for (int unsigned m = 0; m < NUM_MACRO; m++) begin
      for (int unsigned s = 0; s < MAX_NUM_FILTER; s++) begin
        wf_d[slot_index(m, s, MAX_NUM_FILTER)*BIT_OUT_CH +: BIT_OUT_CH] =
          macro_idx[m][s*BIT_OUT_CH +: BIT_OUT_CH];
        fv_d[slot_index(m, s, MAX_NUM_FILTER)] = macro_vld[m][s];
      end
    end
  end

  assign accept  = in_valid && (state_q == IDLE);
  assign advance = (state_q == BUSY) && out_ready && !out_last;
  assign finish  = (state_q == BUSY) && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WHICH_FILTER <= '0;
      FILTER_VLD   <= '0;
      out_last     <= 1'b0;
      rem_q        <= '0;
    end else if (accept || advance) begin
      WHICH_FILTER <= wf_d;
      FILTER_VLD   <= fv_d;
      out_last     <= ~|rem_d;
      rem_q        <= rem_d;
    end else if (finish) begin
      WHICH_FILTER <= '0;
      FILTER_VLD   <= '0;
      out_last     <= 1'b0;
      rem_q        <= '0;
    end
  end

endmodule

// File: tb/tb_filter_sel_encoder.sv
// Self-checking bench: a default encoder and a 2-macro/2-slot encoder,
// compared against a list-based beat model.
module tb_filter_sel_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (1 macro, 64 channels, 1 slot)
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic [63:0] sel_a;
  logic [5:0]  wf_a;
  logic [0:0]  fv_a;

  // Instance B: 2 macros, 16 channels, 2 slots
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [31:0] sel_b;
  logic [15:0] wf_b;
  logic [3:0]  fv_b;

  filter_sel_encoder u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .SEL_MASK(sel_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .WHICH_FILTER(wf_a), .FILTER_VLD(fv_a), .out_last(out_last_a)
  );

  filter_sel_encoder #(.NUM_MACRO(2), .OUT_CH(16), .MAX_NUM_FILTER(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .SEL_MASK(sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .WHICH_FILTER(wf_b), .FILTER_VLD(fv_b), .out_last(out_last_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_wf [0:127];
  logic [7:0]   exp_fv [0:127];
  bit           exp_last [0:127];
  int           exp_n;

  // Reference: list each macro's set channels, then beat b slot s takes list entry b*mf+s.
  task automatic model(input logic [127:0] mask, input int nm, input int oc,
                       input int mf, input int bw);
    int lst [4][128];
    int cnt [4];
    int need, k, j;
    for (int m = 0; m < nm; m++) begin
      cnt[m] = 0;
      for (int c = 0; c < oc; c++)
        if (mask[m*oc + c]) begin lst[m][cnt[m]] = c; cnt[m]++; end
    end
    exp_n = 1;
    for (int m = 0; m < nm; m++) begin
      need = (cnt[m] + mf - 1) / mf;
      if (need > exp_n) exp_n = need;
    end
    for (int b = 0; b < exp_n; b++) begin
      exp_wf[b] = '0;
      exp_fv[b] = '0;
      for (int m = 0; m < nm; m++)
        for (int s = 0; s < mf; s++) begin
          k = m*mf + s;
          j = b*mf + s;
          if (j < cnt[m]) begin
            exp_wf[b] = exp_wf[b] | (128'(lst[m][j]) << (k*bw));
            exp_fv[b][k] = 1'b1;
          end
        end
      exp_last[b] = (b == exp_n - 1);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sends one mask to instance A and follows all its beats; optional random stalls.
  task automatic burst_a(input logic [63:0] mask, input bit stall);
    logic [9:0] got, exp;
    int b, cyc;
    model(128'(mask), 1, 64, 1, 6);
    n_cmp++;
    if (in_ready_a !== 1'b1) begin
      n_bad++; $display("FAIL a_idle_ready mask=%h got=%b exp=1", mask, in_ready_a);
    end
    in_valid_a = 1'b1; sel_a = mask; out_ready_a = 1'b0;
    step();
    in_valid_a = 1'b0; sel_a = {$urandom, $urandom};
    b = 0; cyc = 0;
    while (b < exp_n && cyc < 1000) begin
      got = {out_valid_a, in_ready_a, out_last_a, fv_a, wf_a};
      exp = {1'b1, 1'b0, exp_last[b], exp_fv[b][0], exp_wf[b][5:0]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL a_beat mask=%h beat=%0d got=%h exp=%h", mask, b, got, exp);
      end
      out_ready_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready_a) b++;
      step(); cyc++;
    end
    n_cmp++;
    if (b < exp_n) begin
      n_bad++; $display("FAIL a_timeout mask=%h got=%0d beats exp=%0d", mask, b, exp_n);
    end
    n_cmp++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      n_bad++; $display("FAIL a_return_idle mask=%h got=%b exp=01", mask, {out_valid_a, in_ready_a});
    end
  endtask

  task automatic burst_b(input logic [31:0] mask, input bit stall);
    logic [22:0] got, exp;
    int b, cyc;
    model(128'(mask), 2, 16, 2, 4);
    n_cmp++;
    if (in_ready_b !== 1'b1) begin
      n_bad++; $display("FAIL b_idle_ready mask=%h got=%b exp=1", mask, in_ready_b);
    end
    in_valid_b = 1'b1; sel_b = mask; out_ready_b = 1'b0;
    step();
    in_valid_b = 1'b0; sel_b = $urandom;
    b = 0; cyc = 0;
    while (b < exp_n && cyc < 1000) begin
      got = {out_valid_b, in_ready_b, out_last_b, fv_b, wf_b};
      exp = {1'b1, 1'b0, exp_last[b], exp_fv[b][3:0], exp_wf[b][15:0]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL b_beat mask=%h beat=%0d got=%h exp=%h", mask, b, got, exp);
      end
      out_ready_b = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready_b) b++;
      step(); cyc++;
    end
    n_cmp++;
    if (b < exp_n) begin
      n_bad++; $display("FAIL b_timeout mask=%h got=%0d beats exp=%0d", mask, b, exp_n);
    end
    n_cmp++;
    if ({out_valid_b, in_ready_b} !== 2'b01) begin
      n_bad++; $display("FAIL b_return_idle mask=%h got=%b exp=01", mask, {out_valid_b, in_ready_b});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_a = 1'b0; sel_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; sel_b = '0; out_ready_b = 1'b0;
    #2;
    n_cmp++;
    if ({in_ready_a, out_valid_a, out_last_a, fv_a, wf_a} !== 10'b10_0000_0000) begin
      n_bad++; $display("FAIL reset_a got=%b exp=1000000000", {in_ready_a, out_valid_a, out_last_a, fv_a, wf_a});
    end
    n_cmp++;
    if ({in_ready_b, out_valid_b, out_last_b, fv_b, wf_b} !== {2'b10, 21'd0}) begin
      n_bad++; $display("FAIL reset_b got=%h exp=%h", {in_ready_b, out_valid_b, out_last_b, fv_b, wf_b}, {2'b10, 21'd0});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();      burst_a(64'h20, 1'b0); endtask
  task automatic test_multi();       burst_a((64'h1 << 63) | (64'h1 << 9) | 64'h1, 1'b0); endtask
  task automatic test_empty();       burst_a(64'h0, 1'b0); endtask
  task automatic test_two_macro();   burst_b(32'h0080_000E, 1'b0); endtask

  task automatic test_backpressure();
    logic [8:0] got;
    in_valid_a = 1'b1; sel_a = 64'h18; out_ready_a = 1'b0;
    step();
    in_valid_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = {out_valid_a, in_ready_a, out_last_a, wf_a};
      n_cmp++;
      if (got !== {3'b100, 6'd3}) begin
        n_bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, got, {3'b100, 6'd3});
      end
      in_valid_a  = (i == 1);
      sel_a       = 64'hFF;
      out_ready_a = (i == 4);
      step();
    end
    in_valid_a = 1'b0;
    got = {out_valid_a, in_ready_a, out_last_a, wf_a};
    n_cmp++;
    if (got !== {3'b101, 6'd4}) begin
      n_bad++; $display("FAIL stall_second got=%h exp=%h", got, {3'b101, 6'd4});
    end
    step();
    n_cmp++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      n_bad++; $display("FAIL stall_idle got=%b exp=01", {out_valid_a, in_ready_a});
    end
  endtask

  task automatic test_reset_mid_burst();
    in_valid_a = 1'b1; sel_a = (64'h1 << 63) | (64'h1 << 9) | 64'h1; out_ready_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    n_cmp++;
    if ({out_valid_a, wf_a} !== {1'b1, 6'd0}) begin
      n_bad++; $display("FAIL rst_mid_beat0 got=%h exp=%h", {out_valid_a, wf_a}, {1'b1, 6'd0});
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_a, out_valid_a, out_last_a, fv_a, wf_a} !== 10'b10_0000_0000) begin
      n_bad++; $display("FAIL rst_mid_clear got=%b exp=1000000000", {in_ready_a, out_valid_a, out_last_a, fv_a, wf_a});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    burst_a(64'h1, 1'b0);
  endtask

  task automatic test_random_a();
    logic [63:0] m;
    for (int i = 0; i < 25; i++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (i % 7 == 0) m = '0;
      burst_a(m, 1'b1);
    end
  endtask

  task automatic test_random_b();
    logic [31:0] m;
    for (int i = 0; i < 30; i++) begin
      m = (i % 3 == 0) ? $urandom : ($urandom & $urandom);
      if (i % 11 == 5) m = '0;
      burst_b(m, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_empty();
    test_backpressure();
    test_two_macro();
    test_reset_mid_burst();
    test_random_a();
    test_random_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
